// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding and default widths.
package reg_share_arbiter_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  // IDLE picks a writer and captures its data; COMMIT moves the captured data to q.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] win,
  output logic [N-1:0]  onehot
);

  logic w_found;
  int   w_idx;

  // Scan ptr, ptr+1, ... N-1, 0, ... ptr-1 and keep the first requester seen.
  always_comb begin
    any     = |req;
    win     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        win     = SW'(w_idx);
        w_found = 1'b1;
      end
    end
    onehot = any ? (N'(1) << win) : '0;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Shares one W-bit register between N requesters. A round-robin winner is captured
// into a stage register in IDLE and committed to q in the following COMMIT cycle.
//
// Handshake: a requester holds req[i] and its data slice stable until it sees gnt[i]
// (the cycle its data has been captured), and drops req[i] by the edge ending that
// cycle; a req still high in the next IDLE cycle is a new write.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int W  = DEF_W,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  input  logic           freeze,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic [W-1:0]   q,
  output logic [SW-1:0]  q_src,
  output logic           q_valid,
  output logic           upd,
  output state_e         dbg_state,
  output logic [SW-1:0]  dbg_ptr
);

  state_e        r_state;
  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_stage;
  logic [SW-1:0] r_src;
  logic [N-1:0]  r_gnt;
  logic [W-1:0]  r_q;
  logic [SW-1:0] r_q_src;
  logic          r_q_valid;
  logic          r_upd;

  logic          w_any;
  logic [SW-1:0] w_win;
  logic [N-1:0]  w_onehot;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .any    (w_any),
    .win    (w_win),
    .onehot (w_onehot)
  );

  // FSM with stage, pointer and output registers; reset discards any captured data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_stage   <= '0;
      r_src     <= '0;
      r_gnt     <= '0;
      r_q       <= '0;
      r_q_src   <= '0;
      r_q_valid <= 1'b0;
      r_upd     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_upd <= 1'b0;
          if (!freeze && w_any) begin
            r_stage <= wdata[int'(w_win)*W +: W];
            r_src   <= w_win;
            r_gnt   <= w_onehot;
            r_state <= ST_COMMIT;
          end else begin
            r_gnt <= '0;
          end
        end
        ST_COMMIT: begin
          // The writer just served drops to lowest priority for the next pick.
          r_q       <= r_stage;
          r_q_src   <= r_src;
          r_q_valid <= 1'b1;
          r_upd     <= 1'b1;
          r_gnt     <= '0;
          r_ptr     <= (r_src == SW'(N-1)) ? '0 : r_src + SW'(1);
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state == ST_COMMIT);
  assign q         = r_q;
  assign q_src     = r_q_src;
  assign q_valid   = r_q_valid;
  assign upd       = r_upd;
  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

endmodule
